// File: rtl/cont_servo_pwm_pkg.sv
// Shared definitions for cont_servo_pwm: FSM state type, default frame timing, command-to-width mapping.
package servo_pkg;

  localparam int DEF_FRAME_CYCLES  = 200000;
  localparam int DEF_CENTER_CYCLES = 15000;
  localparam int DEF_STEP_CYCLES   = 39;
  localparam int DEF_MIN_CYCLES    = 10000;
  localparam int DEF_MAX_CYCLES    = 20000;
  localparam int DEF_CMD_W         = 8;
  localparam int DEF_WDOG_FRAMES   = 25;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  function automatic logic [31:0] clamp_width(input int raw, input int lo, input int hi);
    logic [31:0] res;
    if (raw < lo) begin
      res = 32'(lo);
    end else if (raw > hi) begin
      res = 32'(hi);
    end else begin
      res = 32'(raw);
    end
    return res;
  endfunction

  // cmd_sext is the already sign-extended command; the product stays in 32-bit signed range.
  function automatic logic [31:0] cmd_width(input int cmd_sext, input int center, input int step,
                                            input int lo, input int hi);
    return clamp_width(center + (cmd_sext * step), lo, hi);
  endfunction

endpackage

// File: rtl/cont_servo_pwm_if.sv
// Valid/ready speed-command channel from the MSS fabric interface into cont_servo_pwm.
interface cont_servo_pwm_if
  import servo_pkg::*;
#(
  parameter int CMD_W = DEF_CMD_W
);

  logic [CMD_W-1:0] CMD_DATA;
  logic             CMD_VALID;
  logic             CMD_READY;

  modport master (output CMD_DATA, output CMD_VALID, input CMD_READY);
  modport slave  (input CMD_DATA, input CMD_VALID, output CMD_READY);

endinterface

// File: rtl/cont_servo_pwm_frame_ctr.sv
// Frame position counter: steps 0..FRAME_CYCLES-1 while running and parks at 0 whenever the
// stage is idle, so every (re)start begins a full frame.
module servo_frame_ctr #(
  parameter int FRAME_CYCLES = 200000,
  parameter int CNT_W        = $clog2(FRAME_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             run_nxt_i,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             first_o,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Advance only when running in this and the next cycle; a start or stop lands on 0.
  always_comb begin
    cnt_d = {CNT_W{1'b0}};
    if (run_i && run_nxt_i) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_nxt_o = cnt_d;
  assign first_o   = run_i && (cnt_q == {CNT_W{1'b0}});
  assign last_o    = run_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/cont_servo_pwm.sv
// Continuous-rotation servo PWM stage: double-buffered signed speed commands applied at frame
// boundaries. Define SERVO_WDOG_EN to add the command-silence watchdog that forces neutral.
module cont_servo_pwm
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES  = DEF_FRAME_CYCLES,
  parameter int CENTER_CYCLES = DEF_CENTER_CYCLES,
  parameter int STEP_CYCLES   = DEF_STEP_CYCLES,
  parameter int MIN_CYCLES    = DEF_MIN_CYCLES,
  parameter int MAX_CYCLES    = DEF_MAX_CYCLES,
  parameter int CMD_W         = DEF_CMD_W
`ifdef SERVO_WDOG_EN
  ,
  parameter int WDOG_FRAMES   = DEF_WDOG_FRAMES
`endif
) (
  input  logic             SYSCLK,
  input  logic             SYSRESET,
  cont_servo_pwm_if.slave  cmd_if,
  input  logic             ENABLE,
  output logic             PWM_OUT,
  output logic             FRAME_START,
  output logic [CMD_W-1:0] ACTIVE_CMD,
  output logic             WDOG_TRIP
);

  localparam int          CNT_W    = $clog2(FRAME_CYCLES);
  localparam logic [31:0] CENTER_W = 32'(CENTER_CYCLES);

  state_e           state_q, state_d;
  logic [CMD_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [CMD_W-1:0] active_q, active_d;
  logic [31:0]      width_q, width_d;
  logic             pwm_q, pwm_d;
  logic             init_q;

  logic [CNT_W-1:0] cnt_nxt_s;
  logic             frame_first_s;
  logic             frame_last_s;
  logic             ready_s;
  logic             hs_s;
  logic             boundary_s;
  logic             load_pend_s;
  logic             wdog_load_s;
  logic [31:0]      pend_width_s;

  servo_frame_ctr #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .CNT_W        (CNT_W)
  ) u_frame_ctr (
    .clk       (SYSCLK),
    .rst       (SYSRESET),
    .run_i     (state_q == S_RUN),
    .run_nxt_i (state_d == S_RUN),
    .cnt_nxt_o (cnt_nxt_s),
    .first_o   (frame_first_s),
    .last_o    (frame_last_s)
  );

  // init_q keeps READY low through reset and the release edge.
  assign ready_s      = init_q && !pend_vld_q;
  assign hs_s         = cmd_if.CMD_VALID && ready_s;
  assign boundary_s   = ENABLE && ((state_q == S_IDLE) || frame_last_s);
  assign load_pend_s  = boundary_s && pend_vld_q;
  assign pend_width_s = cmd_width(int'($signed(pend_q)), CENTER_CYCLES, STEP_CYCLES,
                                  MIN_CYCLES, MAX_CYCLES);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ENABLE) state_d = S_RUN;
        else        state_d = S_IDLE;
      end
      S_RUN: begin
        if (ENABLE) state_d = S_RUN;
        else        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // READY is low whenever pend is full, so a handshake never coincides with a pend load.
  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    active_d   = active_q;
    width_d    = width_q;
    if (hs_s) begin
      pend_d     = cmd_if.CMD_DATA;
      pend_vld_d = 1'b1;
    end else if (load_pend_s) begin
      pend_vld_d = 1'b0;
    end else begin
      pend_vld_d = pend_vld_q;
    end
    if (load_pend_s) begin
      active_d = pend_q;
      width_d  = pend_width_s;
    end else if (wdog_load_s) begin
      active_d = {CMD_W{1'b0}};
      width_d  = CENTER_W;
    end else begin
      active_d = active_q;
      width_d  = width_q;
    end
  end

  // PWM is computed from next-cycle count/width so the registered pin lines up with cnt.
  assign pwm_d = (state_d == S_RUN) && (32'(cnt_nxt_s) < width_d);

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      state_q    <= S_IDLE;
      pend_q     <= {CMD_W{1'b0}};
      pend_vld_q <= 1'b0;
      active_q   <= {CMD_W{1'b0}};
      width_q    <= CENTER_W;
      pwm_q      <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      active_q   <= active_d;
      width_q    <= width_d;
      pwm_q      <= pwm_d;
      init_q     <= 1'b1;
    end
  end

`ifdef SERVO_WDOG_EN
  localparam int              WD_W    = $clog2(WDOG_FRAMES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_FRAMES - 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            trip_q, trip_d;

  // Counts boundaries that found pend empty; saturates so every later silent boundary re-trips.
  always_comb begin
    wd_cnt_d    = wd_cnt_q;
    trip_d      = trip_q;
    wdog_load_s = 1'b0;
    if (hs_s) begin
      wd_cnt_d = {WD_W{1'b0}};
      trip_d   = 1'b0;
    end else if (load_pend_s) begin
      wd_cnt_d = {WD_W{1'b0}};
    end else if (boundary_s) begin
      if (wd_cnt_q >= WD_LAST) begin
        wd_cnt_d    = WD_LAST;
        trip_d      = 1'b1;
        wdog_load_s = 1'b1;
      end else begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
    end else begin
      wd_cnt_d = wd_cnt_q;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      wd_cnt_q <= {WD_W{1'b0}};
      trip_q   <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      trip_q   <= trip_d;
    end
  end

  assign WDOG_TRIP = trip_q;
`else
  assign wdog_load_s = 1'b0;
  assign WDOG_TRIP   = 1'b0;
`endif

  assign cmd_if.CMD_READY = ready_s;
  assign PWM_OUT          = pwm_q;
  assign FRAME_START      = frame_first_s;
  assign ACTIVE_CMD       = active_q;

endmodule
